lsu_mem_bridge: RTL and testbench

LSU_MEM_BRIDGE -- requirements
Module: lsu_mem_bridge

---
 rtl/npc_lsu_pkg.sv | 61 ++++++
 rtl/lsu_lane_align.sv | 49 ++++
 rtl/lsu_mem_bridge.sv | 158 +++++++++++++++
 tb/tb_lsu_mem_bridge.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_lsu_pkg.sv
// Shared FSM states, RV32I load/store funct3 codes and access-size helpers
// used by the LSU-to-memory bridge and its lane-alignment datapath.
package npc_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    lsu_size_e sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_BYTE;
      F3_H, F3_HU: sz = SZ_HALF;
      default:     sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  // Stores only have the signed encodings; the unsigned ones are load-only.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end else begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

  function automatic logic misaligned(input lsu_size_e sz, input logic [1:0] off);
    return ((sz == SZ_HALF) && (off == 2'b11)) ||
           ((sz == SZ_WORD) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] size_strobe(input lsu_size_e sz);
    logic [3:0] strb;
    case (sz)
      SZ_BYTE: strb = 4'b0001;
      SZ_HALF: strb = 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: store strobes and data replication, and
// load lane extraction with sign/zero extension.
module lsu_lane_align
  import npc_lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        we_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  lsu_size_e   size;
  logic [4:0]  shamt;
  logic [31:0] lane;

  assign size  = f3_size(funct3_i);
  assign shamt = {offset_i, 3'b000};

  // A 4-bit shift drops strobe bits past lane 3, clipping to the addressed word.
  assign wstrb_o = we_i ? 4'(size_strobe(size) << offset_i) : 4'b0000;

  assign lane = rdata_i >> shamt;

  always_comb begin
    wdata_o = wdata_i;
    case (size)
      SZ_BYTE: wdata_o = {4{wdata_i[7:0]}};
      SZ_HALF: wdata_o = {2{wdata_i[15:0]}};
      default: wdata_o = wdata_i;
    endcase
  end

  always_comb begin
    load_o = '0;
    case (funct3_i)
      F3_B:    load_o = {{24{lane[7]}}, lane[7:0]};
      F3_H:    load_o = {{16{lane[15]}}, lane[15:0]};
      F3_W:    load_o = lane;
      F3_BU:   load_o = {24'h000000, lane[7:0]};
      F3_HU:   load_o = {16'h0000, lane[15:0]};
      default: load_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Single-outstanding bridge from an LSU request/response port to a word memory.
// Define LSU_BRIDGE_MISALIGN_TRAP_EN to reject misaligned accesses with resp_err.
module lsu_mem_bridge
  import npc_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  lsu_state_e  state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        reqBad;
  logic        timeoutHit;
  logic [3:0]  alignWstrb;
  logic [31:0] alignWdata;
  logic [31:0] alignLoad;

  assign accept     = req_valid && req_ready;
  assign timeoutHit = (cnt_q == CntLast);

`ifdef LSU_BRIDGE_MISALIGN_TRAP_EN
  assign reqBad = !f3_legal(req_we, req_funct3) ||
                  misaligned(f3_size(req_funct3), req_addr[1:0]);
`else
  assign reqBad = !f3_legal(req_we, req_funct3);
`endif

  lsu_lane_align u_align (
    .funct3_i (funct3_q),
    .we_i     (we_q),
    .offset_i (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .rdata_i  (mem_rdata),
    .wstrb_o  (alignWstrb),
    .wdata_o  (alignWdata),
    .load_o   (alignLoad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = reqBad ? ST_RESP : ST_REQ;
      ST_REQ:  if (mem_ready) state_d = ST_WAIT;
      ST_WAIT: if (mem_rvalid || timeoutHit) state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == ST_IDLE) && rst_n;
    mem_valid  = (state_q == ST_REQ);
    resp_valid = (state_q == ST_RESP);
    mem_we     = we_q;
    mem_addr   = {addr_q[31:2], 2'b00};
    mem_wdata  = alignWdata;
    mem_wstrb  = alignWstrb;
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

  // Request fields are captured once at accept and held for the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end
  end

  always_comb begin
    cnt_d = '0;
    if ((state_q == ST_WAIT) && !mem_rvalid && !timeoutHit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rdata_d = '0;
          err_d   = reqBad;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = we_q ? 32'h0 : alignLoad;
          err_d   = 1'b0;
        end else if (timeoutHit) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed bench for lsu_mem_bridge: loads, stores, backpressure, timeout,
// illegal/misaligned requests and mid-transaction reset.
module tb_lsu_mem_bridge;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int nAsserts = 0;
  int nFails   = 0;

  lsu_mem_bridge #(.TIMEOUT_CYC(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = valid;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Full load transaction with no stalls; memory answers on the first WAIT cycle.
  task automatic runLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] expData);
    applyStimulus(1'b1, 1'b0, f3, addr, 32'h0);
    mem_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    checkOutput({tag, " mem_valid"}, 32'(mem_valid), 32'd1);
    checkOutput({tag, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
    checkOutput({tag, " mem_wstrb"}, 32'(mem_wstrb), 32'd0);
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    checkOutput({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    checkOutput({tag, " resp_rdata"}, resp_rdata, expData);
    checkOutput({tag, " resp_err"}, 32'(resp_err), 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checkOutput({tag, " idle req_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic runStore(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] expStrb,
                          input logic [31:0] expWdata);
    applyStimulus(1'b1, 1'b1, f3, addr, wdata);
    mem_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    checkOutput({tag, " mem_valid"}, 32'(mem_valid), 32'd1);
    checkOutput({tag, " mem_we"}, 32'(mem_we), 32'd1);
    checkOutput({tag, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
    checkOutput({tag, " mem_wstrb"}, 32'(mem_wstrb), 32'(expStrb));
    checkOutput({tag, " mem_wdata"}, mem_wdata, expWdata);
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    tick();
    mem_rvalid = 1'b0;
    checkOutput({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    checkOutput({tag, " resp_rdata"}, resp_rdata, 32'h0);
    checkOutput({tag, " resp_err"}, 32'(resp_err), 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    int waitCycles;
    rst_n      = 1'b0;
    resp_ready = 1'b0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

    #3;
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset resp_err", 32'(resp_err), 32'd0);
    checkOutput("reset resp_rdata", resp_rdata, 32'h0);
    checkOutput("reset mem_wstrb", 32'(mem_wstrb), 32'd0);
    checkOutput("reset mem_addr", mem_addr, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("post-reset req_ready", 32'(req_ready), 32'd1);

    $display("[TB] loads with sign/zero extension");
    runLoad("lb3", 3'b000, 32'h8000_0003, 32'h80AA_BBCC, 32'hFFFF_FF80);
    runLoad("lh0", 3'b001, 32'h8000_0000, 32'h80AA_BBCC, 32'hFFFF_BBCC);
    runLoad("lhu2", 3'b101, 32'h8000_0002, 32'h80AA_BBCC, 32'h0000_80AA);
    runLoad("lbu1", 3'b100, 32'h8000_0001, 32'h80AA_BBCC, 32'h0000_00BB);
    runLoad("lw4", 3'b010, 32'h8000_0004, 32'h1234_5678, 32'h1234_5678);

    $display("[TB] stores with strobes and lane replication");
    runStore("sh2", 3'b001, 32'h8000_0002, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
    runStore("sb1", 3'b000, 32'h8000_0001, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5);
    runStore("sw8", 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    $display("[TB] memory and response backpressure");
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0);
    mem_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp mem_valid held", 32'(mem_valid), 32'd1);
      checkOutput("bp mem_addr held", mem_addr, 32'h8000_0010);
      checkOutput("bp mem_we held", 32'(mem_we), 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    checkOutput("bp mem_valid at ready", 32'(mem_valid), 32'd1);
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1122_3344;
    checkOutput("bp mem_valid dropped", 32'(mem_valid), 32'd0);
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp resp_valid held", 32'(resp_valid), 32'd1);
      checkOutput("bp resp_rdata held", resp_rdata, 32'h1122_3344);
      checkOutput("bp resp_err held", 32'(resp_err), 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    checkOutput("bp resp_valid at ready", 32'(resp_valid), 32'd1);
    tick();
    resp_ready = 1'b0;
    checkOutput("bp resp_valid cleared", 32'(resp_valid), 32'd0);

    $display("[TB] response timeout");
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h8000_0020, 32'h0);
    mem_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    mem_ready  = 1'b0;
    mem_rdata  = 32'hFFFF_FFFF;
    waitCycles = 0;
    while (!resp_valid && waitCycles < 40) begin
      waitCycles++;
      tick();
    end
    checkOutput("timeout wait cycles", 32'(waitCycles), 32'd16);
    checkOutput("timeout resp_valid", 32'(resp_valid), 32'd1);
    checkOutput("timeout resp_err", 32'(resp_err), 32'd1);
    checkOutput("timeout resp_rdata", resp_rdata, 32'h0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    mem_rdata  = 32'h0;

    $display("[TB] illegal funct3");
    applyStimulus(1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'h0);
    mem_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    checkOutput("illegal mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("illegal resp_valid", 32'(resp_valid), 32'd1);
    checkOutput("illegal resp_err", 32'(resp_err), 32'd1);
    checkOutput("illegal resp_rdata", resp_rdata, 32'h0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    $display("[TB] misaligned word load");
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'h0);
    mem_ready = 1'b1;
    tick();
    req_valid = 1'b0;
`ifdef LSU_BRIDGE_MISALIGN_TRAP_EN
    checkOutput("misalign mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("misalign resp_valid", 32'(resp_valid), 32'd1);
    checkOutput("misalign resp_err", 32'(resp_err), 32'd1);
    checkOutput("misalign resp_rdata", resp_rdata, 32'h0);
`else
    checkOutput("misalign mem_valid", 32'(mem_valid), 32'd1);
    checkOutput("misalign mem_addr", mem_addr, 32'h8000_0000);
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hAABB_CCDD;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    checkOutput("misalign resp_valid", 32'(resp_valid), 32'd1);
    checkOutput("misalign resp_err", 32'(resp_err), 32'd0);
    checkOutput("misalign resp_rdata", resp_rdata, 32'h00AA_BBCC);
`endif
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    mem_ready  = 1'b0;

    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h8000_0040, 32'h0);
    mem_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    mem_ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset req_ready", 32'(req_ready), 32'd0);
    checkOutput("midreset mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("midreset resp_valid", 32'(resp_valid), 32'd0);
    tick();
    tick();
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0055;
    #1;
    checkOutput("release req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("late rvalid resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("late rvalid mem_valid", 32'(mem_valid), 32'd0);
    end
    mem_rvalid = 1'b0;
    checkOutput("final req_ready", 32'(req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
